// File: rtl/pr_stage_skid.sv
// Pipeline stage register with a 2-entry skid buffer: 1-cycle latency, full throughput.
// IN_READY is decoded from registered occupancy only; flush squashes both slots to bubbles.
module pr_stage_skid #(
  parameter int DATA_WIDTH = 101,
  parameter int CTRL_WIDTH = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  FLUSH,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [DATA_WIDTH-1:0] IN_DATA,
  input  logic [CTRL_WIDTH-1:0] IN_CTRL,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic [CTRL_WIDTH-1:0] OUT_CTRL,
  output logic [1:0]            OCCUPANCY
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
  logic [CTRL_WIDTH-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic [CTRL_WIDTH-1:0] skid_ctrl_q, skid_ctrl_d;
  logic                  push, pop;

  assign IN_READY  = (state_q != FULL);
  assign OUT_VALID = (state_q != EMPTY);
  assign OUT_DATA  = main_data_q;
  assign OUT_CTRL  = main_ctrl_q;
  assign OCCUPANCY = state_q;

  assign push = IN_VALID & IN_READY;
  assign pop  = OUT_VALID & OUT_READY;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;

    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d     = ONE;
          main_data_d = IN_DATA;
          main_ctrl_d = IN_CTRL;
        end
      end
      ONE: begin
        if (push && pop) begin
          main_data_d = IN_DATA;
          main_ctrl_d = IN_CTRL;
        end else if (push) begin
          state_d     = FULL;
          skid_data_d = IN_DATA;
          skid_ctrl_d = IN_CTRL;
        end else if (pop) begin
          state_d     = EMPTY;
          main_ctrl_d = '0;
        end
      end
      FULL: begin
        // Skid entry moves into the main slot; the vacated skid slot becomes a bubble.
        if (pop) begin
          state_d     = ONE;
          main_data_d = skid_data_q;
          main_ctrl_d = skid_ctrl_q;
          skid_ctrl_d = '0;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Squash discards any same-cycle handshake; payload bits just keep their old value.
    if (FLUSH) begin
      state_d     = EMPTY;
      main_data_d = main_data_q;
      skid_data_d = skid_data_q;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

endmodule

// File: tb/tb_pr_stage_skid.sv
// Directed, table-driven bench for pr_stage_skid plus hand-written flush/reset sequences.
module tb_pr_stage_skid;

  localparam int DW = 101;
  localparam int CW = 4;

  logic          CLK;
  logic          RESET;
  logic          FLUSH;
  logic          IN_VALID;
  logic          IN_READY;
  logic [DW-1:0] IN_DATA;
  logic [CW-1:0] IN_CTRL;
  logic          OUT_VALID;
  logic          OUT_READY;
  logic [DW-1:0] OUT_DATA;
  logic [CW-1:0] OUT_CTRL;
  logic [1:0]    OCCUPANCY;

  pr_stage_skid #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .FLUSH     (FLUSH),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_DATA   (IN_DATA),
    .IN_CTRL   (IN_CTRL),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_DATA  (OUT_DATA),
    .OUT_CTRL  (OUT_CTRL),
    .OCCUPANCY (OCCUPANCY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string         name;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_ready;
    logic          exp_valid;
    logic          chk_data;
    logic [DW-1:0] exp_data;
    logic [CW-1:0] exp_ctrl;
    logic [1:0]    exp_occ;
    logic          exp_rdy;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   passed = 0;

  function automatic vec_t mk(string name, logic rst, logic flush, logic in_valid,
                              logic [DW-1:0] in_data, logic [CW-1:0] in_ctrl, logic out_ready,
                              logic exp_valid, logic chk_data, logic [DW-1:0] exp_data,
                              logic [CW-1:0] exp_ctrl, logic [1:0] exp_occ, logic exp_rdy);
    vec_t v;
    v.name = name; v.rst = rst; v.flush = flush; v.in_valid = in_valid;
    v.in_data = in_data; v.in_ctrl = in_ctrl; v.out_ready = out_ready;
    v.exp_valid = exp_valid; v.chk_data = chk_data; v.exp_data = exp_data;
    v.exp_ctrl = exp_ctrl; v.exp_occ = exp_occ; v.exp_rdy = exp_rdy;
    return v;
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    else passed++;
  endtask

  // Drive between edges, clock once, then sample just after the edge.
  task automatic apply(vec_t v);
    @(negedge CLK);
    RESET     = v.rst;
    FLUSH     = v.flush;
    IN_VALID  = v.in_valid;
    IN_DATA   = v.in_data;
    IN_CTRL   = v.in_ctrl;
    OUT_READY = v.out_ready;
    @(posedge CLK);
    #1;
    check({v.name, ".out_valid"}, 128'(OUT_VALID), 128'(v.exp_valid));
    check({v.name, ".out_ctrl"},  128'(OUT_CTRL),  128'(v.exp_ctrl));
    check({v.name, ".occupancy"}, 128'(OCCUPANCY), 128'(v.exp_occ));
    check({v.name, ".in_ready"},  128'(IN_READY),  128'(v.exp_rdy));
    if (v.chk_data) check({v.name, ".out_data"}, 128'(OUT_DATA), 128'(v.exp_data));
  endtask

  initial begin
    RESET = 1'b1; FLUSH = 1'b0; IN_VALID = 1'b0; IN_DATA = '0; IN_CTRL = '0; OUT_READY = 1'b0;

    //              name      rst flu iv  in_data  ctrl  ordy  ev  cd  exp_data ectl  occ rdy
    vecs.push_back(mk("rst0",  1, 0, 1, 'h5A,  4'hF, 0,   0, 1, 'h0,   4'h0, 0, 1));
    vecs.push_back(mk("rst1",  1, 0, 1, 'h5A,  4'hF, 0,   0, 1, 'h0,   4'h0, 0, 1));
    vecs.push_back(mk("str0",  0, 0, 1, 'h10,  4'hF, 1,   1, 1, 'h10,  4'hF, 1, 1));
    vecs.push_back(mk("str1",  0, 0, 1, 'h11,  4'hF, 1,   1, 1, 'h11,  4'hF, 1, 1));
    vecs.push_back(mk("str2",  0, 0, 1, 'h12,  4'hF, 1,   1, 1, 'h12,  4'hF, 1, 1));
    vecs.push_back(mk("str3",  0, 0, 1, 'h13,  4'hF, 1,   1, 1, 'h13,  4'hF, 1, 1));
    vecs.push_back(mk("str4",  0, 0, 1, 'h14,  4'hF, 1,   1, 1, 'h14,  4'hF, 1, 1));
    vecs.push_back(mk("strE",  0, 0, 0, 'h0,   4'h0, 1,   0, 0, 'h0,   4'h0, 0, 1));
    vecs.push_back(mk("bpA",   0, 0, 1, 'h100, 4'h1, 0,   1, 1, 'h100, 4'h1, 1, 1));
    vecs.push_back(mk("bpB",   0, 0, 1, 'h200, 4'h2, 0,   1, 1, 'h100, 4'h1, 2, 0));
    vecs.push_back(mk("bpCh",  0, 0, 1, 'h300, 4'h3, 0,   1, 1, 'h100, 4'h1, 2, 0));
    vecs.push_back(mk("bpOB",  0, 0, 1, 'h300, 4'h3, 1,   1, 1, 'h200, 4'h2, 1, 1));
    vecs.push_back(mk("bpOC",  0, 0, 1, 'h300, 4'h3, 1,   1, 1, 'h300, 4'h3, 1, 1));
    vecs.push_back(mk("bpE",   0, 0, 0, 'h0,   4'h0, 1,   0, 0, 'h0,   4'h0, 0, 1));
    vecs.push_back(mk("bub1",  0, 0, 1, 'h55,  4'hB, 1,   1, 1, 'h55,  4'hB, 1, 1));
    vecs.push_back(mk("bub2",  0, 0, 0, 'h0,   4'h0, 1,   0, 0, 'h0,   4'h0, 0, 1));
    vecs.push_back(mk("bub3",  0, 0, 0, 'h0,   4'h0, 1,   0, 0, 'h0,   4'h0, 0, 1));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Flush while FULL: A, B and the offered entry must never emerge.
    apply(mk("flA",  0, 0, 1, 'hA1, 4'h5, 0,  1, 1, 'hA1, 4'h5, 1, 1));
    apply(mk("flB",  0, 0, 1, 'hB2, 4'h6, 0,  1, 1, 'hA1, 4'h5, 2, 0));
    apply(mk("flF",  0, 1, 1, 'hC3, 4'h7, 1,  0, 0, 'h0,  4'h0, 0, 1));
    for (int i = 0; i < 3; i++)
      apply(mk("flIdle", 0, 0, 0, 'h0, 4'h0, 1,  0, 0, 'h0, 4'h0, 0, 1));

    // RESET wins over FLUSH and a simultaneous push/pop while ONE.
    apply(mk("rfOne", 0, 0, 1, 'h77, 4'h9, 0,  1, 1, 'h77, 4'h9, 1, 1));
    apply(mk("rfBoth", 1, 1, 1, 'h88, 4'hA, 1,  0, 1, 'h0,  4'h0, 0, 1));
    for (int i = 0; i < 2; i++)
      apply(mk("rfIdle", 0, 0, 0, 'h0, 4'h0, 1,  0, 1, 'h0, 4'h0, 0, 1));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
